// File: rtl/sa_output_collector_if.sv
// Downstream row interface of the systolic output collector: one aligned row of
// partial sums with a valid/ready handshake.
interface sa_output_collector_if #(
  parameter int WORD_WIDTH = 8,
  parameter int COLS       = 4
);
  localparam int ROW_W = COLS * 4 * WORD_WIDTH;

  logic [ROW_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sa_output_collector.sv
// Drain side of the weight-stationary PE array: deskews the bottom-row outputs,
// packs aligned compute rows into a small FIFO and flags skew/overflow faults.
module sa_output_collector #(
  parameter int WORD_WIDTH = 8,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [COLS*4*WORD_WIDTH-1:0]  ps_in,
  input  logic [COLS*2-1:0]             ctrl_in,
  sa_output_collector_if.master         out_if,
  output logic [15:0]                   row_count,
  output logic                          overflow,
  output logic                          skew_err,
  input  logic                          clear_flags
);
  localparam int PS_W  = 4 * WORD_WIDTH;
  localparam int ROW_W = COLS * PS_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] TAG_COMPUTE = 2'b10;

  logic [COLS-1:0][PS_W-1:0] aligned_row;
  logic [COLS-1:0][1:0]      aligned_tag;
  logic [COLS-1:0]           col_compute;

  // Column j waits COLS-1-j cycles so every column of one compute step lines up
  // with the undelayed last column.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    localparam int STAGES = COLS - 1 - gi;
    if (STAGES == 0) begin : g_direct
      assign aligned_row[gi] = ps_in[gi*PS_W +: PS_W];
      assign aligned_tag[gi] = ctrl_in[2*gi +: 2];
    end else begin : g_delay
      logic [PS_W-1:0] data_q [STAGES];
      logic [1:0]      tag_q  [STAGES];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < STAGES; s++) begin
            data_q[s] <= '0;
            tag_q[s]  <= '0;
          end
        end else begin
          data_q[0] <= ps_in[gi*PS_W +: PS_W];
          tag_q[0]  <= ctrl_in[2*gi +: 2];
          for (int s = 1; s < STAGES; s++) begin
            data_q[s] <= data_q[s-1];
            tag_q[s]  <= tag_q[s-1];
          end
        end
      end

      assign aligned_row[gi] = data_q[STAGES-1];
      assign aligned_tag[gi] = tag_q[STAGES-1];
    end
    assign col_compute[gi] = (aligned_tag[gi] == TAG_COMPUTE);
  end

  logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      row_count_q, row_count_d;
  logic             overflow_q, overflow_d;
  logic             skew_err_q, skew_err_d;

  logic all_compute, any_compute, fifo_full, fifo_empty;
  logic pop, push, overflow_event, skew_event;

  always_comb begin
    all_compute    = &col_compute;
    any_compute    = |col_compute;
    fifo_full      = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty     = (count_q == '0);
    pop            = !fifo_empty && out_if.out_ready;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    push           = all_compute && (!fifo_full || pop);
    overflow_event = all_compute && fifo_full && !pop;
    skew_event     = any_compute && !all_compute;

    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (clear_flags) begin
      row_count_d = {15'd0, push};
      overflow_d  = overflow_event;
      skew_err_d  = skew_event;
    end else begin
      row_count_d = row_count_q + {15'd0, push};
      overflow_d  = overflow_q | overflow_event;
      skew_err_d  = skew_err_q | skew_event;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < FIFO_DEPTH; e++) mem_q[e] <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      row_count_q <= '0;
      overflow_q  <= 1'b0;
      skew_err_q  <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= aligned_row;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      row_count_q <= row_count_d;
      overflow_q  <= overflow_d;
      skew_err_q  <= skew_err_d;
    end
  end

  assign out_if.out_data  = mem_q[rd_ptr_q];
  assign out_if.out_valid = !fifo_empty;
  assign row_count        = row_count_q;
  assign overflow         = overflow_q;
  assign skew_err         = skew_err_q;
endmodule

// File: doc/sa_output_collector.md
Name: sa_output_collector

Overview:
- Drain-side companion to the weight-stationary PE array; receives partial-sum outputs and propagated control of the bottom PE row.
- Removes the column-to-column skew of the systolic output.
- Packs one aligned row of COLS partial sums per compute step into a small FIFO.
- Presents rows downstream with a valid/ready handshake.
- Flags skew and overflow errors.

Parameters:
- WORD_WIDTH, 8, PE operand width; each partial sum is 4*WORD_WIDTH bits.
- COLS, 4, number of array columns (>=2).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- ps_in  input  COLS*4*WORD_WIDTH  bottom-row d_out; column j at bits [j*4W +: 4W]
- ctrl_in  input  COLS*2  bottom-row control_out; column j at bits [2j +: 2]
- out_data  output  COLS*4*WORD_WIDTH  aligned row; column j at bits [j*4W +: 4W]
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  downstream accepts out_data
- row_count  output  16  rows written to FIFO since reset/clear, wraps at 2^16
- overflow  output  1  sticky: a row was dropped because the FIFO was full
- skew_err  output  1  sticky: aligned columns disagreed on compute tag
- clear_flags  input  1  synchronous; clears overflow, skew_err, row_count

Behaviour:
- Reset is decided: reset_n is asynchronous and active-low; clock is clk.
- Reset values: out_valid=0, out_data=0, row_count=0, overflow=0, skew_err=0. Reset also clears all deskew registers, FIFO pointers and the FIFO count.
- Sample tagging: a column sample is a compute sample iff its ctrl is 2'b10. Tags 00, 01 and 11 are non-compute; 01 weight-load echoes are never stored.
- Deskew: column j is delayed by COLS-1-j register stages, carrying both data and tag. Column COLS-1 has zero delay; column 0 has COLS-1 stages. Deskew registers shift every cycle regardless of FIFO state.
- Aligned row at cycle t: {column 0 delayed output, ..., column COLS-1 direct input}.
- Write condition: all COLS aligned tags are 2'b10 -> row pushed at the end of cycle t.
- Skew error: if some but not all aligned tags are 10, set skew_err and do not push. skew_err holds until clear_flags or reset.
- FIFO: synchronous, registered storage; no bypass.
  - A row pushed at the end of cycle t drives out_valid=1 in cycle t+1.
  - out_data always shows the head entry; its value is don't-care when out_valid=0 (implement as 0 after reset).
- Pop: occurs on any cycle with out_valid && out_ready. The head advances at that edge.
- Push while full with no pop: row dropped, overflow set, row_count unchanged.
- Push while full with a simultaneous pop: push accepted, count unchanged, no overflow.
- Push and pop on a non-empty, non-full FIFO: both occur, count unchanged.
- Pointer arithmetic: read/write pointers wrap modulo FIFO_DEPTH. A count register of clog2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- row_count increments by 1 on each accepted push and wraps 0xFFFF->0.
- clear_flags: in the same cycle as an accepted push, row_count becomes 1 and flags become 0, except that a new overflow/skew event in that cycle sets its flag.
- Arithmetic: none beyond pointers and counters; partial sums pass through unmodified at 4*WORD_WIDTH bits.
- Reset mid-operation: asynchronously empties the FIFO and deskew chain. out_valid drops immediately; any partial row in flight is lost.

Test Plan (COLS=4, WORD_WIDTH=8, FIFO_DEPTH=4):
1. Reset: assert reset_n=0 mid-stream -> out_valid=0, row_count=0, flags 0, same cycle; after release, first emitted row comes only from post-reset samples.
2. Skewed single row: col j presents ps=0x100+j with ctrl=10 in cycle t0+j, ctrl=00 otherwise, out_ready=1 -> out_valid=1 in cycle t0+4 only, out_data={0x103,0x102,0x101,0x100}, row_count=1, skew_err=0.
3. Weight-load filter: all columns ctrl=01 skewed with ps=0x0000007F -> no FIFO push, out_valid stays 0, row_count=0.
4. Backpressure/overflow: out_ready=0, feed 5 skewed compute rows back-to-back -> out_valid=1, 4 rows stored, overflow=1 after the 5th, row_count=4. Then out_ready=1 -> rows 1..4 emitted in order on 4 consecutive cycles, then out_valid=0.
5. Full with simultaneous push/pop: FIFO full, out_ready=1 in the same cycle a 5th row aligns -> no overflow, row_count=5, emission order preserved.
6. Skew fault: column 2 ctrl=10 one cycle late -> skew_err=1, no push. Then clear_flags=1 for one cycle -> skew_err=0, row_count=0.
